// File: rtl/datapath_seq_pkg.sv
// Shared types and encodings for the self-sequencing datapath.
package datapath_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StExec,
    StWb
  } state_e;

  // ALU operation encodings
  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluSub = 2'b01;
  localparam logic [1:0] AluAnd = 2'b10;
  localparam logic [1:0] AluNot = 2'b11;

  // Shift encodings applied to the B register path
  localparam logic [1:0] ShNone = 2'b00;
  localparam logic [1:0] ShLsl  = 2'b01;
  localparam logic [1:0] ShLsr  = 2'b10;
  localparam logic [1:0] ShAsr  = 2'b11;

  // Width-independent control part of a captured command
  typedef struct packed {
    logic [1:0] shift;
    logic [1:0] aluop;
    logic       asel;
    logic       bsel;
    logic       vsel;
    logic       wb;
  } cmd_ctrl_t;

endpackage

// File: rtl/dp_alu_shift.sv
// Combinational B-path shifter, operand select, 4-op ALU and {N,V,Z} flags.
module dp_alu_shift
  import datapath_seq_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_imm,
  input  logic [1:0]   i_shift,
  input  logic [1:0]   i_aluop,
  input  logic         i_asel,
  input  logic         i_bsel,
  output logic [W-1:0] o_result,
  output logic [2:0]   o_flags
);

  logic [W-1:0] w_shifted;
  logic [W-1:0] w_opa;
  logic [W-1:0] w_opb;
  logic [W-1:0] w_res;
  logic         w_ovf;

  // Shift the B register value; the immediate bypasses the shifter
  always_comb begin
    w_shifted = i_b;
    case (i_shift)
      ShNone:  w_shifted = i_b;
      ShLsl:   w_shifted = {i_b[W-2:0], 1'b0};
      ShLsr:   w_shifted = {1'b0, i_b[W-1:1]};
      ShAsr:   w_shifted = {i_b[W-1], i_b[W-1:1]};
      default: w_shifted = i_b;
    endcase
  end

  // Operand selection, ALU and overflow detection
  always_comb begin
    w_opa = i_asel ? '0 : i_a;
    w_opb = i_bsel ? i_imm : w_shifted;
    w_res = '0;
    w_ovf = 1'b0;
    case (i_aluop)
      AluAdd: begin
        w_res = w_opa + w_opb;
        w_ovf = (w_opa[W-1] == w_opb[W-1]) && (w_res[W-1] != w_opa[W-1]);
      end
      AluSub: begin
        w_res = w_opa - w_opb;
        w_ovf = (w_opa[W-1] != w_opb[W-1]) && (w_res[W-1] != w_opa[W-1]);
      end
      AluAnd:  w_res = w_opa & w_opb;
      AluNot:  w_res = ~w_opb;
      default: w_res = '0;
    endcase
  end

  // Drive result and {N, V, Z}
  always_comb begin
    o_result = w_res;
    o_flags  = {w_res[W-1], w_ovf, (w_res == '0)};
  end

endmodule

// File: rtl/datapath_seq.sv
// Self-sequencing datapath: command capture, 5-state sequencer, register bank,
// A/B/C operand registers and status flags.
module datapath_seq
  import datapath_seq_pkg::*;
#(
  parameter int unsigned W    = 16,
  parameter int unsigned NREG = 8,
  parameter int unsigned IMMW = 5,
  localparam int unsigned RW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [RW-1:0] cmd_rd,
  input  logic [RW-1:0] cmd_rn,
  input  logic [RW-1:0] cmd_rm,
  input  logic [1:0]    cmd_shift,
  input  logic [1:0]    cmd_aluop,
  input  logic          cmd_asel,
  input  logic          cmd_bsel,
  input  logic          cmd_vsel,
  input  logic          cmd_wb,
  input  logic [W-1:0]  datapath_in,
  output logic [W-1:0]  datapath_out,
  output logic [2:0]    status,
  output logic          done
);

  state_e       r_state;
  state_e       w_state_next;
  cmd_ctrl_t    r_ctrl;
  logic [RW-1:0] r_rd;
  logic [RW-1:0] r_rn;
  logic [RW-1:0] r_rm;
  logic [W-1:0] r_data;
  logic [W-1:0] r_regs [NREG];
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_c;
  logic [2:0]   r_status;
  logic         w_accept;
  logic [W-1:0] w_imm;
  logic [W-1:0] w_result;
  logic [2:0]   w_flags;

  assign w_accept = cmd_valid & cmd_ready;
  assign w_imm    = W'(r_data[IMMW-1:0]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: moves skip straight to write-back
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_next = cmd_vsel ? StWb : StLoadA;
        end
      end
      StLoadA: w_state_next = StLoadB;
      StLoadB: w_state_next = StExec;
      StExec:  w_state_next = StWb;
      StWb:    w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    cmd_ready = (r_state == StIdle);
    done      = (r_state == StWb);
  end

  // Command register: captured once at acceptance, ignores inputs afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= '0;
      r_rd   <= '0;
      r_rn   <= '0;
      r_rm   <= '0;
      r_data <= '0;
    end else if (w_accept) begin
      r_ctrl <= '{shift: cmd_shift, aluop: cmd_aluop, asel: cmd_asel,
                  bsel: cmd_bsel, vsel: cmd_vsel, wb: cmd_wb};
      r_rd   <= cmd_rd;
      r_rn   <= cmd_rn;
      r_rm   <= cmd_rm;
      r_data <= datapath_in;
    end
  end

  // Register bank write at the end of WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (r_state == StWb && r_ctrl.wb) begin
      r_regs[r_rd] <= r_ctrl.vsel ? r_data : r_c;
    end
  end

  // Operand loads and EXEC result/flag capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_status <= '0;
    end else begin
      if (r_state == StLoadA) r_a <= r_regs[r_rn];
      if (r_state == StLoadB) r_b <= r_regs[r_rm];
      if (r_state == StExec) begin
        r_c      <= w_result;
        r_status <= w_flags;
      end
    end
  end

  dp_alu_shift #(
    .W(W)
  ) u_alu (
    .i_a     (r_a),
    .i_b     (r_b),
    .i_imm   (w_imm),
    .i_shift (r_ctrl.shift),
    .i_aluop (r_ctrl.aluop),
    .i_asel  (r_ctrl.asel),
    .i_bsel  (r_ctrl.bsel),
    .o_result(w_result),
    .o_flags (w_flags)
  );

  // Registered outputs
  always_comb begin
    datapath_out = r_c;
    status       = r_status;
  end

endmodule

// File: tb/tb_datapath_seq.sv
// Directed, scoreboard-based bench for datapath_seq.
module tb_datapath_seq;
  localparam int W    = 16;
  localparam int NREG = 8;
  localparam int IMMW = 5;
  localparam int RW   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [RW-1:0] cmd_rd = '0, cmd_rn = '0, cmd_rm = '0;
  logic [1:0]    cmd_shift = '0, cmd_aluop = '0;
  logic          cmd_asel = 1'b0, cmd_bsel = 1'b0, cmd_vsel = 1'b0, cmd_wb = 1'b0;
  logic [W-1:0]  datapath_in = '0;
  logic [W-1:0]  datapath_out;
  logic [2:0]    status;
  logic          done;

  always #5 clk = ~clk;

  datapath_seq #(.W(W), .NREG(NREG), .IMMW(IMMW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_shift(cmd_shift),
    .cmd_aluop(cmd_aluop), .cmd_asel(cmd_asel), .cmd_bsel(cmd_bsel),
    .cmd_vsel(cmd_vsel), .cmd_wb(cmd_wb), .datapath_in(datapath_in),
    .datapath_out(datapath_out), .status(status), .done(done)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] out;
    logic [2:0]   st;
    int           lat;
  } exp_t;
  exp_t scb[$];

  logic [W-1:0] m_regs [NREG];
  logic [W-1:0] m_c;
  logic [2:0]   m_st;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model of one command, using wide signed arithmetic for V
  function automatic void model(input logic [RW-1:0] rd, rn, rm, input logic [1:0] sh, op,
                                input logic asel, bsel, vsel, wb, input logic [W-1:0] data);
    logic [W-1:0] a, b, r;
    int sa, sbv, sr;
    logic v;
    if (vsel) begin
      if (wb) m_regs[rd] = data;
      return;
    end
    a = asel ? '0 : m_regs[rn];
    if (bsel) begin
      b = '0;
      b[IMMW-1:0] = data[IMMW-1:0];
    end else begin
      case (sh)
        2'd0: b = m_regs[rm];
        2'd1: b = m_regs[rm] << 1;
        2'd2: b = m_regs[rm] >> 1;
        default: b = $signed(m_regs[rm]) >>> 1;
      endcase
    end
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    v   = 1'b0;
    case (op)
      2'd0: begin r = a + b; sr = sa + sbv; v = (sr > 32767) || (sr < -32768); end
      2'd1: begin r = a - b; sr = sa - sbv; v = (sr > 32767) || (sr < -32768); end
      2'd2: r = a & b;
      default: r = ~b;
    endcase
    m_c  = r;
    m_st = {r[W-1], v, (r == '0)};
    if (wb) m_regs[rd] = r;
  endfunction

  // Drive one command, push its expectation, then pop and compare at done
  task automatic issue(input string tag, input logic [RW-1:0] rd, rn, rm,
                       input logic [1:0] sh, op, input logic asel, bsel, vsel, wb,
                       input logic [W-1:0] data);
    exp_t e;
    int n;
    bit seen;
    @(negedge clk);
    check({tag, ":ready"}, W'(cmd_ready), W'(1));
    cmd_rd = rd; cmd_rn = rn; cmd_rm = rm; cmd_shift = sh; cmd_aluop = op;
    cmd_asel = asel; cmd_bsel = bsel; cmd_vsel = vsel; cmd_wb = wb; datapath_in = data;
    cmd_valid = 1'b1;
    model(rd, rn, rm, sh, op, asel, bsel, vsel, wb, data);
    e.out = m_c; e.st = m_st; e.lat = vsel ? 0 : 3;
    scb.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    datapath_in = 16'hDEAD;  // must be ignored after acceptance
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    e = scb.pop_front();
    check({tag, ":done_seen"}, W'(seen), W'(1));
    if (seen) begin
      check({tag, ":latency"}, W'(n), W'(e.lat));
      check({tag, ":out"}, datapath_out, e.out);
      check({tag, ":status"}, W'(status), W'(e.st));
      @(negedge clk);
      check({tag, ":done_pulse"}, W'(done), W'(0));
    end
  endtask

  // Read R[r] through the datapath: C = 0 + R[r], no write-back
  task automatic read_reg(input string tag, input logic [RW-1:0] r, input logic [W-1:0] expv);
    issue(tag, 3'd0, 3'd0, r, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    check({tag, ":const"}, datapath_out, expv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    m_c = '0;
    m_st = '0;

    // Power-on reset
    #1 rst_n = 1'b0;
    #2;
    check("rst_out", datapath_out, '0);
    check("rst_status", W'(status), '0);
    check("rst_ready", W'(cmd_ready), W'(1));
    check("rst_done", W'(done), W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Populate state, then reset during an ALU command
    issue("pre_mv4", 3'd4, 3'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234);
    issue("pre_add", 3'd5, 3'd4, 3'd4, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("pre_add_val", datapath_out, 16'h2468);
    @(negedge clk);
    cmd_rd = 3'd6; cmd_rn = 3'd4; cmd_rm = 3'd5; cmd_shift = 2'd0; cmd_aluop = 2'd0;
    cmd_asel = 1'b0; cmd_bsel = 1'b0; cmd_vsel = 1'b0; cmd_wb = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out", datapath_out, '0);
    check("midrst_status", W'(status), '0);
    check("midrst_ready", W'(cmd_ready), W'(1));
    check("midrst_done", W'(done), W'(0));
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    m_c = '0;
    m_st = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < NREG; r++) read_reg($sformatf("rst_R%0d", r), RW'(r), '0);

    // Moves and ADD with LSL
    issue("mv_r0", 3'd0, 3'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd7);
    check("mv_r0_out_hold", datapath_out, '0);
    issue("mv_r1", 3'd1, 3'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2);
    issue("add_lsl", 3'd2, 3'd0, 3'd1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("add_lsl_val", datapath_out, 16'd11);
    check("add_lsl_st", W'(status), W'(3'b000));
    // rn=2 read via A path plus immediate 0
    issue("rd_r2", 3'd0, 3'd2, 3'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("rd_r2_val", datapath_out, 16'd11);

    // SUB negative result
    issue("sub", 3'd3, 3'd1, 3'd0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("sub_val", datapath_out, 16'hFFFB);
    check("sub_st", W'(status), W'(3'b100));

    // Signed overflow via immediate (upper datapath_in bits must be dropped)
    issue("mv_r6", 3'd6, 3'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h7FFF);
    issue("add_ovf", 3'd7, 3'd6, 3'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFE1);
    check("add_ovf_val", datapath_out, 16'h8000);
    check("add_ovf_st", W'(status), W'(3'b110));

    // Compare without write-back
    issue("cmp", 3'd3, 3'd0, 3'd0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("cmp_st", W'(status), W'(3'b001));
    read_reg("r3_kept", 3'd3, 16'hFFFB);

    // Remaining shift and ALU encodings
    issue("and", 3'd4, 3'd3, 3'd0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("and_val", datapath_out, 16'h0003);
    issue("not_asr", 3'd5, 3'd0, 3'd3, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("not_asr_val", datapath_out, 16'h0002);
    issue("lsr", 3'd5, 3'd0, 3'd3, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
    check("lsr_val", datapath_out, 16'h7FFD);
    issue("sub_ovf", 3'd4, 3'd7, 3'd1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Back-to-back ALU commands with cmd_valid held high
    @(negedge clk);
    cmd_rd = 3'd0; cmd_rn = 3'd0; cmd_rm = 3'd0; cmd_shift = 2'd0; cmd_aluop = 2'd1;
    cmd_asel = 1'b0; cmd_bsel = 1'b0; cmd_vsel = 1'b0; cmd_wb = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("cont_alu_ready%0d", i), W'(cmd_ready), W'(i % 5 == 0));
      check($sformatf("cont_alu_done%0d", i), W'(done), W'(i % 5 == 4));
      if (i % 5 == 0) model(3'd0, 3'd0, 3'd0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("cont_alu_out", datapath_out, m_c);
    check("cont_alu_st", W'(status), W'(3'b001));

    // Back-to-back moves with cmd_valid held high
    cmd_rd = 3'd5; cmd_vsel = 1'b1; cmd_wb = 1'b1; datapath_in = 16'd3;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("cont_mv_ready%0d", i), W'(cmd_ready), W'(i % 2 == 0));
      check($sformatf("cont_mv_done%0d", i), W'(done), W'(i % 2 == 1));
      if (i % 2 == 0) model(3'd5, 3'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd3);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    cmd_vsel = 1'b0;
    read_reg("cont_mv_r5", 3'd5, 16'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_seq.md
# datapath_seq

Parametrised, self-sequencing successor to the lab datapath. It accepts one ALU or move command per handshake and steps internally through read-A, read-B, execute and write-back. It holds a W-bit × NREG register bank, a barrel-lite shifter, a 4-op ALU and a 3-flag status register. It sits between the instruction decoder (command source) and the memory/IO path (`datapath_in` / `datapath_out`).

## Interface
Parameters:
- `W`, 16, datapath and register width (≥ 4)
- `NREG`, 8, number of general registers (power of two, ≥ 2); `RW = $clog2(NREG)`
- `IMMW`, 5, immediate field width used when `bsel=1` (≤ W)

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  block can accept a command
- `cmd_rd`, `cmd_rn`, `cmd_rm`  in  RW each  destination, A-source and B-source register
- `cmd_shift`  in  2  shift applied to B operand
- `cmd_aluop`  in  2  ALU operation
- `cmd_asel`  in  1  1: A operand forced to 0
- `cmd_bsel`  in  1  1: B operand = zero-extended `datapath_in[IMMW-1:0]`
- `cmd_vsel`  in  1  1: move command, write `datapath_in` directly to `cmd_rd`
- `cmd_wb`  in  1  1: write result to `cmd_rd`; 0: flags/C only (compare)
- `datapath_in`  in  W  immediate/move data, sampled at acceptance
- `datapath_out`  out  W  C register
- `status`  out  3  {N, V, Z} status register
- `done`  out  1  one-cycle pulse during the write-back cycle

## Operation
- FSM states: IDLE, LOADA, LOADB, EXEC, WB.
- In IDLE, `cmd_ready=1`. In every other state, `cmd_ready=0`.
- Acceptance occurs on an edge with `cmd_valid & cmd_ready`. At acceptance, all `cmd_*` fields and `datapath_in` are captured into a command register. Inputs are ignored afterwards.
- Move (`vsel=1`): IDLE → WB. In WB, `R[rd] ← captured datapath_in` (if `wb=1`). A, B, C and status are unchanged.
- ALU (`vsel=0`): IDLE → LOADA → LOADB → EXEC → WB → IDLE.
  - LOADA: `A ← R[rn]`.
  - LOADB: `B ← R[rm]`.
  - EXEC: `C ← alu(Ain, shift(B))`; status ← flags.
  - WB: `R[rd] ← C` if `wb=1`.
- Shift encodings:
  - 00: none
  - 01: left by 1, zero fill
  - 10: logical right by 1
  - 11: arithmetic right by 1 (MSB replicated)
- The shift applies only to the B register path, never to the immediate.
- ALU encodings, all modulo 2^W:
  - 00: A+B
  - 01: A−B
  - 10: A&B
  - 11: ~B
- Flags:
  - Z = (result == 0).
  - N = result[W-1].
  - V = signed overflow for ADD/SUB; 0 for AND/NOT.
- Register reads are of the value at the sampling edge. If `rn` or `rm` equals the `rd` of the immediately preceding command, the read returns the already-written value (the write completes at the end of WB, before IDLE).

## Timing
- Reset (asynchronous, while `rst_n=0`):
  - state = IDLE, `cmd_ready=1`, `done=0`
  - all registers R[0..NREG-1], A, B and C = 0
  - `datapath_out = 0`, `status = 3'b000`
- A reset asserted mid-command aborts the command. No register write occurs unless the WB edge has already passed.
- ALU command accepted at edge k:
  - LOADA during cycle k+1
  - `done=1` during cycle k+4
  - register write at edge k+5
  - `cmd_ready=1` again from cycle k+5
  - Throughput: one ALU command per 5 cycles.
- Move command accepted at edge k: `done=1` during cycle k+1, write at edge k+2, ready from cycle k+2.
- `datapath_out` and `status` change only at the EXEC→WB edge. They hold otherwise.
- `done` is asserted even when `wb=0`.

## Structure
- Package `datapath_seq_pkg`:
  - state enum
  - ALU op localparams (ADD/SUB/AND/NOT)
  - shift localparams (NONE/LSL/LSR/ASR)
  - command struct type
- Sub-module `dp_alu_shift` (combinational): shift + ALU + {N,V,Z} flag generation, parametrised by W.
- The top level holds the FSM, command register, register bank, A/B/C and status flops.

## Test plan
- Reset with W=16: drive `rst_n=0` mid-command → `datapath_out=0`, `status=000`, `cmd_ready=1`, and a subsequent read of every R returns 0.
- Move R0←7, then move R1←2, then ADD R2=R0+(R1 LSL 1) with `wb=1` → `done` in cycle k+4, `datapath_out=11`, `status=000`; a later `rn=2` read returns 11.
- SUB R3 = R1−R0 (2−7) → `datapath_out=16'hFFFB`, N=1, Z=0, V=0.
- ADD 16'h7FFF + immediate 1 (`bsel=1`) → result 16'h8000, N=1, V=1.
- Compare with `wb=0`: R0 − R0 → Z=1; R3 is unchanged.
- Hold `cmd_valid=1` continuously → acceptances are exactly 5 cycles apart (ALU) or 2 cycles apart (move), and `cmd_ready` is 0 in every non-IDLE cycle.
